// File: rtl/input_holder.sv
// Receive side of the user byte interface: synchronises the user strobe, captures the byte,
// delivers it to the cipher as a one-cycle pulse and completes a 4-phase handshake.
module input_holder #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  cipher_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_pulse,
    output logic                  ack_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    valid_sync_s;
    logic                    capture_s;
    logic [DATA_WIDTH-1:0]   data_out_r;
    logic                    pulse_r;
    logic                    ack_r;
    logic                    busy_r;

    assign valid_sync_s = sync_r[SYNC_STAGES-1];
    // data_in is quasi-static while the strobe is high, so only the strobe needs synchronising
    assign capture_s    = (state_r == ST_IDLE) && valid_sync_s;

    // Synchroniser chain for the asynchronous user strobe
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], valid_in};
        end
    end

    // Handshake state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_sync_s) begin
                    state_next_s = ST_PENDING;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // The byte is delivered even if the strobe has already been withdrawn
                if (cipher_ready) begin
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_PENDING;
                end
            end
            ST_ACK: begin
                if (!valid_sync_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, aligned with the state they describe
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_out_r <= {DATA_WIDTH{1'b0}};
            pulse_r    <= 1'b0;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (capture_s) begin
                data_out_r <= data_in;
            end else begin
                data_out_r <= data_out_r;
            end
            pulse_r <= (state_r == ST_PENDING) && cipher_ready;
            ack_r   <= (state_next_s == ST_ACK);
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    assign data_out       = data_out_r;
    assign data_out_pulse = pulse_r;
    assign ack_out        = ack_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_input_holder.sv
// Directed self-checking bench for input_holder: handshake timing, back-pressure,
// held strobe, abort, asynchronous reset and back-to-back transfers.
module tb_input_holder;

    logic       clk;
    logic       nrst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       cipher_ready;
    logic [7:0] data_out;
    logic       data_out_pulse;
    logic       ack_out;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pulse_cnt = 0;
    logic [7:0] pulse_data = 8'h00;
    int base_cnt;

    input_holder #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .cipher_ready   (cipher_ready),
        .data_out       (data_out),
        .data_out_pulse (data_out_pulse),
        .ack_out        (ack_out),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled away from the active edge
    always @(negedge clk) begin
        if (data_out_pulse === 1'b1) begin
            pulse_cnt  = pulse_cnt + 1;
            pulse_data = data_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic handshake(input logic [7:0] b, input string tag);
        data_in      = b;
        valid_in     = 1'b1;
        cipher_ready = 1'b1;
        tick(3);
        check({tag, "_capture"}, {24'd0, data_out}, {24'd0, b});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick(1);
        check({tag, "_pulse"}, {31'd0, data_out_pulse}, 32'd1);
        check({tag, "_ack"}, {31'd0, ack_out}, 32'd1);
        valid_in = 1'b0;
        tick(3);
        check({tag, "_ack_low"}, {31'd0, ack_out}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        nrst         = 1'b0;
        data_in      = 8'h00;
        valid_in     = 1'b0;
        cipher_ready = 1'b0;
        tick(3);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_pulse", {31'd0, data_out_pulse}, 32'd0);
        check("rst_ack", {31'd0, ack_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        nrst = 1'b1;
        tick(2);

        // 1. Basic transfer with latency checks
        data_in = 8'hA5; valid_in = 1'b1; cipher_ready = 1'b1;
        tick(2);
        check("basic_e1_busy", {31'd0, busy}, 32'd0);
        check("basic_e1_data", {24'd0, data_out}, 32'd0);
        tick(1);
        check("basic_e2_data", {24'd0, data_out}, 32'h0000_00A5);
        check("basic_e2_busy", {31'd0, busy}, 32'd1);
        check("basic_e2_pulse", {31'd0, data_out_pulse}, 32'd0);
        check("basic_e2_ack", {31'd0, ack_out}, 32'd0);
        tick(1);
        check("basic_e3_pulse", {31'd0, data_out_pulse}, 32'd1);
        check("basic_e3_ack", {31'd0, ack_out}, 32'd1);
        tick(1);
        check("basic_e4_pulse", {31'd0, data_out_pulse}, 32'd0);
        check("basic_e4_ack", {31'd0, ack_out}, 32'd1);
        valid_in = 1'b0;
        tick(2);
        check("basic_ack_hold", {31'd0, ack_out}, 32'd1);
        tick(1);
        check("basic_ack_fall", {31'd0, ack_out}, 32'd0);
        check("basic_busy_fall", {31'd0, busy}, 32'd0);
        check("basic_pulses", pulse_cnt, 32'd1);

        // 2. Back-pressure
        data_in = 8'h3C; valid_in = 1'b1; cipher_ready = 1'b0;
        tick(3);
        check("bp_capture", {24'd0, data_out}, 32'h0000_003C);
        tick(10);
        check("bp_no_pulse", pulse_cnt, 32'd1);
        check("bp_busy", {31'd0, busy}, 32'd1);
        check("bp_ack", {31'd0, ack_out}, 32'd0);
        cipher_ready = 1'b1;
        tick(1);
        check("bp_pulse", {31'd0, data_out_pulse}, 32'd1);
        check("bp_pulse_data", {24'd0, data_out}, 32'h0000_003C);
        valid_in = 1'b0;
        tick(3);
        check("bp_idle", {31'd0, busy}, 32'd0);
        check("bp_pulses", pulse_cnt, 32'd2);

        // 3. Held strobe with data changing mid-way
        base_cnt = pulse_cnt;
        data_in = 8'h5A; valid_in = 1'b1; cipher_ready = 1'b1;
        tick(25);
        data_in = 8'h11;
        tick(25);
        check("held_one_pulse", pulse_cnt - base_cnt, 32'd1);
        check("held_pulse_data", {24'd0, pulse_data}, 32'h0000_005A);
        check("held_data_out", {24'd0, data_out}, 32'h0000_005A);
        check("held_ack", {31'd0, ack_out}, 32'd1);
        valid_in = 1'b0;
        tick(3);
        check("held_idle", {31'd0, busy}, 32'd0);
        check("held_no_recapture", {24'd0, data_out}, 32'h0000_005A);

        // 4. Abort while pending
        base_cnt = pulse_cnt;
        data_in = 8'hC3; valid_in = 1'b1; cipher_ready = 1'b0;
        tick(3);
        valid_in = 1'b0;
        tick(4);
        check("abort_busy", {31'd0, busy}, 32'd1);
        check("abort_no_pulse", pulse_cnt - base_cnt, 32'd0);
        check("abort_ack0", {31'd0, ack_out}, 32'd0);
        cipher_ready = 1'b1;
        tick(1);
        check("abort_pulse", {31'd0, data_out_pulse}, 32'd1);
        check("abort_data", {24'd0, data_out}, 32'h0000_00C3);
        check("abort_ack1", {31'd0, ack_out}, 32'd1);
        tick(1);
        check("abort_ack_1cyc", {31'd0, ack_out}, 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_pulse_end", {31'd0, data_out_pulse}, 32'd0);

        // 5. Asynchronous reset mid-transaction
        base_cnt = pulse_cnt;
        data_in = 8'hFF; valid_in = 1'b1; cipher_ready = 1'b0;
        tick(3);
        check("rstop_pending", {24'd0, data_out}, 32'h0000_00FF);
        #2;
        nrst = 1'b0;
        #1;
        check("rstop_data", {24'd0, data_out}, 32'd0);
        check("rstop_busy", {31'd0, busy}, 32'd0);
        check("rstop_ack", {31'd0, ack_out}, 32'd0);
        check("rstop_pulse", {31'd0, data_out_pulse}, 32'd0);
        valid_in = 1'b0; cipher_ready = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        tick(4);
        check("rstop_no_pulse", pulse_cnt - base_cnt, 32'd0);
        check("rstop_idle", {31'd0, busy}, 32'd0);
        handshake(8'h42, "post_rst");
        check("post_rst_pulses", pulse_cnt - base_cnt, 32'd1);

        // 6. Back-to-back handshakes
        base_cnt = pulse_cnt;
        handshake(8'h01, "b2b_1");
        check("b2b_1_seq", {24'd0, pulse_data}, 32'h0000_0001);
        handshake(8'h02, "b2b_2");
        check("b2b_2_seq", {24'd0, pulse_data}, 32'h0000_0002);
        handshake(8'h03, "b2b_3");
        check("b2b_3_seq", {24'd0, pulse_data}, 32'h0000_0003);
        check("b2b_count", pulse_cnt - base_cnt, 32'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
